// File: rtl/mult_pkg.sv
// Shared types and width helpers for the sequential shift-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int MULT_N = 8;

    // Counter must hold the value N after the last iteration.
    function automatic int cw_of(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pp_adder_row.sv
// One row of AND + full-adder partial-product cells, rippled with carry-in 0.
module pp_cell (
    input  logic m,
    input  logic qBit,
    input  logic ppIn,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic pp;

    assign pp   = m & qBit;
    assign s    = pp ^ ppIn ^ cin;
    assign cout = (pp & ppIn) | (cin & (pp ^ ppIn));
endmodule

module pp_adder_row #(
    parameter int N = 8
) (
    input  logic [N-1:0] M,
    input  logic         qBit,
    input  logic [N-1:0] ppIn,
    output logic [N-1:0] sum,
    output logic         carryOut
);
    logic [N:0] c;

    assign c[0] = 1'b0;

    for (genvar i = 0; i < N; i++) begin : g_cell
        pp_cell u_cell (
            .m    (M[i]),
            .qBit (qBit),
            .ppIn (ppIn[i]),
            .cin  (c[i]),
            .s    (sum[i]),
            .cout (c[i+1])
        );
    end

    assign carryOut = c[N];
endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Sequential N-bit unsigned shift-add multiplier: one adder row reused over N
// iterations, product presented on a valid/ack handshake.
module shift_add_mult_ctrl
    import mult_pkg::*;
#(
    parameter int N  = MULT_N,
    parameter int CW = cw_of(N)
) (
    input  logic           clk,
    input  logic           resetN,
    input  logic           start,
    input  logic [N-1:0]   inputM,
    input  logic [N-1:0]   inputQ,
    output logic           busy,
    output logic           productValid,
    input  logic           productAck,
    output logic [2*N-1:0] product
);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_e         state_q;
    logic [N-1:0]   m_q, a_q, q_q;
    logic [CW-1:0]  count_q;
    logic [2*N-1:0] product_q;

    logic [N-1:0]   row_sum;
    logic           row_cout;
    logic [2*N-1:0] aq_d;

    pp_adder_row #(.N(N)) u_row (
        .M        (m_q),
        .qBit     (q_q[0]),
        .ppIn     (a_q),
        .sum      (row_sum),
        .carryOut (row_cout)
    );

    // {carry, sum, Q} shifted right by one: carry lands in A's MSB, Q[0] drops.
    assign aq_d = {row_cout, row_sum, q_q[N-1:1]};

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q   <= IDLE;
            m_q       <= '0;
            a_q       <= '0;
            q_q       <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        m_q     <= inputM;
                        q_q     <= inputQ;
                        a_q     <= '0;
                        count_q <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    {a_q, q_q} <= aq_d;
                    count_q    <= count_q + 1'b1;
                    if (count_q == LAST) begin
                        product_q <= aq_d;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    if (productAck) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy         = (state_q != IDLE);
    assign productValid = (state_q == DONE);
    assign product      = product_q;
endmodule
